// File: rtl/formal_chk_pkg.sv
// formal_chk_pkg
// Shared definitions for the formal random checker:
//   - state_t    : run-control FSM states
//   - LFSR_TAPS  : feedback tap mask for the 64-bit Fibonacci LFSR (taps 64,63,61,60)
//   - IDX_W      : width of the RUN-cycle index / first_err_cycle output
//   - lfsr_next  : one Fibonacci shift step
package formal_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bits 63, 62, 60, 59 (taps 64, 63, 61, 60 in 1-based numbering).
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  localparam int IDX_W = 20;

  function automatic logic [63:0] lfsr_next(input logic [63:0] q);
    return {q[62:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/formal_chk_lfsr.sv
// formal_chk_lfsr
// 64-bit Fibonacci LFSR stepping once per cycle while enabled.
// A zero seed would lock the register at zero, so it is replaced by 1.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (loads the seed)
//   i_en       : shift enable
//   o_q        : low OUT_W bits of the current LFSR state
module formal_chk_lfsr
  import formal_chk_pkg::*;
#(
  parameter int          OUT_W = 2,
  parameter logic [63:0] SEED  = 64'h1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  output logic [OUT_W-1:0] o_q
);

  localparam logic [63:0] SEED_FIX = (SEED == 64'h0) ? 64'h1 : SEED;

  logic [63:0] r_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_lfsr <= SEED_FIX;
    else if (i_en) r_lfsr <= lfsr_next(r_lfsr);
  end

  assign o_q = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/formal_random_checker.sv
// formal_random_checker
// Stimulus-and-scoreboard engine: drives LFSR stimulus into a fabric and its
// reference, compares latency-aligned outputs under a don't-care mask, and
// reports a saturating mismatch count and pass/fail after a fixed run.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   start           : begin a run (accepted in IDLE or DONE only)
//   stim            : registered random stimulus
//   dut_out/ref_out : fabric and reference outputs
//   ref_mask        : 1 = bit is don't-care this cycle
//   busy / done     : WARMUP-or-RUN active / run finished
//   pass            : valid in DONE, 1 iff no mismatch was counted
//   err_count       : saturating mismatch count (cycles or episodes)
//   mismatch_bits   : sticky OR of mismatching bits this run
//   first_err_cycle : RUN-cycle index of first mismatch, all-ones if none
module formal_random_checker
  import formal_chk_pkg::*;
#(
  parameter int          NUM_IN        = 2,
  parameter int          NUM_OUT       = 1,
  parameter logic [63:0] SEED          = 64'h1,
  parameter int          WARMUP_CYCLES = 1,
  parameter int          RUN_CYCLES    = 400,
  parameter int          LATENCY       = 0,
  parameter int          COUNT_MODE    = 0,
  parameter int          ERR_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [NUM_IN-1:0]  stim,
  input  logic [NUM_OUT-1:0] dut_out,
  input  logic [NUM_OUT-1:0] ref_out,
  input  logic [NUM_OUT-1:0] ref_mask,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [NUM_OUT-1:0] mismatch_bits,
  output logic [IDX_W-1:0]   first_err_cycle
);

  // One extra bit so RUN_CYCLES + LATENCY (drain) fits.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES + LATENCY - 1);
  localparam logic [CNT_W-1:0] RUN_LEN   = CNT_W'(RUN_CYCLES);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               w_go;
  logic               w_lfsr_en;
  logic [NUM_IN-1:0]  w_lfsr_q;
  logic [NUM_IN-1:0]  r_stim;
  logic               w_src_vld;
  logic               w_cmp_en;
  logic [IDX_W-1:0]   w_cmp_idx;
  logic [NUM_OUT-1:0] w_mism;
  logic               w_any;
  logic               w_inc;
  logic [ERR_W-1:0]   r_err, w_err_nxt;
  logic [NUM_OUT-1:0] r_mbits, w_mbits_nxt;
  logic [IDX_W-1:0]   r_first, w_first_nxt;
  logic               r_prev, w_prev_nxt;
  logic               r_pass;

  // ---- run-control FSM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_go        = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_go        = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (r_cnt == WARM_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        // RUN is stretched by LATENCY cycles so the compare pipeline drains.
        if (r_cnt == RUN_LAST) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (r_state == ST_WARMUP) || (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

  // ---- stimulus ----
  assign w_lfsr_en = busy;

  formal_chk_lfsr #(
    .OUT_W (NUM_IN),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_lfsr_en),
    .o_q   (w_lfsr_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_stim <= '0;
    else if (w_lfsr_en) r_stim <= w_lfsr_q;
  end

  assign stim = r_stim;

  // ---- compare-enable / cycle-index alignment ----
  assign w_src_vld = (r_state == ST_RUN) && (r_cnt < RUN_LEN);

  if (LATENCY == 0) begin : g_nolat
    assign w_cmp_en  = w_src_vld;
    assign w_cmp_idx = r_cnt[IDX_W-1:0];
  end else begin : g_lat
    logic [LATENCY-1:0] r_vld_p;
    logic [IDX_W-1:0]   r_idx_p [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_vld_p <= '0;
      end else begin
        r_vld_p[0] <= w_src_vld;
        for (int i = 1; i < LATENCY; i++) r_vld_p[i] <= r_vld_p[i-1];
      end
    end

    always_ff @(posedge clk) begin
      r_idx_p[0] <= r_cnt[IDX_W-1:0];
      for (int i = 1; i < LATENCY; i++) r_idx_p[i] <= r_idx_p[i-1];
    end

    assign w_cmp_en  = r_vld_p[LATENCY-1];
    assign w_cmp_idx = r_idx_p[LATENCY-1];
  end

  // ---- scoreboard ----
  assign w_mism = (dut_out ^ ref_out) & ~ref_mask;
  assign w_any  = |w_mism;
  assign w_inc  = (COUNT_MODE == 0) ? w_any : (w_any && !r_prev);

  always_comb begin
    w_err_nxt   = r_err;
    w_mbits_nxt = r_mbits;
    w_first_nxt = r_first;
    w_prev_nxt  = r_prev;
    if (w_go) begin
      w_err_nxt   = '0;
      w_mbits_nxt = '0;
      w_first_nxt = '1;
      w_prev_nxt  = 1'b0;
    end else if (w_cmp_en) begin
      w_mbits_nxt = r_mbits | w_mism;
      // The first mismatch of a run always increments, so a zero count
      // identifies it in either counting mode.
      if (w_any && (r_err == '0)) w_first_nxt = w_cmp_idx;
      if (w_inc) w_err_nxt = sat_inc(r_err);
      w_prev_nxt = w_any;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err   <= '0;
      r_mbits <= '0;
      r_first <= '1;
      r_prev  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_err   <= w_err_nxt;
      r_mbits <= w_mbits_nxt;
      r_first <= w_first_nxt;
      r_prev  <= w_prev_nxt;
      // The last compare lands on the DONE-entry edge, so judge the updated count.
      if ((r_state != ST_DONE) && (w_state_nxt == ST_DONE)) r_pass <= (w_err_nxt == '0);
      else if (w_state_nxt != ST_DONE)                         r_pass <= 1'b0;
    end
  end

  assign pass            = r_pass;
  assign err_count       = r_err;
  assign mismatch_bits   = r_mbits;
  assign first_err_cycle = r_first;

endmodule

// File: tb/tb_formal_random_checker.sv
module tb_formal_random_checker;

  localparam logic [63:0] SEED4 = 64'hACE1_2345_6789_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, fault, mask_en;
  int   n_cmp = 0;
  int   n_err = 0;

  // u0: mode 0, u1: mode 1 -- both see the injected fault
  logic [1:0]  stim0, stim1;
  logic        d0, r0, d1, r1;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] err0, err1;
  logic [0:0]  mb0, mb1;
  logic [19:0] fe0, fe1;

  // u2: LATENCY 3, u3: LATENCY 0 (seed 0), both behind a 3-cycle fabric/reference
  logic [1:0]  stim2, stim3;
  logic        d2, r2, m2, d3, r3, m3;
  logic        busy2, done2, pass2, busy3, done3, pass3;
  logic [15:0] err2, err3;
  logic [0:0]  mb2, mb3;
  logic [19:0] fe2, fe3;

  // u4: ERR_W 4, permanently inverted output
  logic [15:0] stim4;
  logic        d4, r4;
  logic        busy4, done4, pass4;
  logic [3:0]  err4;
  logic [0:0]  mb4;
  logic [19:0] fe4;

  assign r0 = ^stim0;  assign d0 = r0 ^ fault;
  assign r1 = ^stim1;  assign d1 = r1 ^ fault;
  assign r4 = stim4[0]; assign d4 = ~stim4[0];

  // Reference delayed 3 cycles (invalid for 3 cycles after reset); fabric
  // shares the data path but outputs garbage (inverted) for 3 cycles after start.
  logic [1:0] lat_stim [2];
  logic [2:0] pipe_p [2];
  logic [2:0] ref_v [2];
  logic [2:0] fab_v [2];
  assign lat_stim[0] = stim2;
  assign lat_stim[1] = stim3;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe_p[k] <= {pipe_p[k][1:0], ^lat_stim[k]};
      ref_v[k]  <= reset ? 3'b000 : {ref_v[k][1:0], 1'b1};
      fab_v[k]  <= start ? 3'b000 : {fab_v[k][1:0], 1'b1};
    end
  end

  assign r2 = pipe_p[0][2]; assign d2 = fab_v[0][2] ? pipe_p[0][2] : ~pipe_p[0][2]; assign m2 = ~ref_v[0][2];
  assign r3 = pipe_p[1][2]; assign d3 = fab_v[1][2] ? pipe_p[1][2] : ~pipe_p[1][2]; assign m3 = ~ref_v[1][2];

  formal_random_checker #(.NUM_IN(2), .NUM_OUT(1), .SEED(64'h1), .WARMUP_CYCLES(1),
    .RUN_CYCLES(400), .LATENCY(0), .COUNT_MODE(0), .ERR_W(16)) u0 (
    .clk(clk), .reset(reset), .start(start), .stim(stim0), .dut_out(d0), .ref_out(r0),
    .ref_mask(mask_en), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .mismatch_bits(mb0), .first_err_cycle(fe0));

  formal_random_checker #(.NUM_IN(2), .NUM_OUT(1), .SEED(64'h1), .WARMUP_CYCLES(1),
    .RUN_CYCLES(400), .LATENCY(0), .COUNT_MODE(1), .ERR_W(16)) u1 (
    .clk(clk), .reset(reset), .start(start), .stim(stim1), .dut_out(d1), .ref_out(r1),
    .ref_mask(mask_en), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .mismatch_bits(mb1), .first_err_cycle(fe1));

  formal_random_checker #(.NUM_IN(2), .NUM_OUT(1), .SEED(64'h1), .WARMUP_CYCLES(1),
    .RUN_CYCLES(400), .LATENCY(3), .COUNT_MODE(0), .ERR_W(16)) u2 (
    .clk(clk), .reset(reset), .start(start), .stim(stim2), .dut_out(d2), .ref_out(r2),
    .ref_mask(m2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .mismatch_bits(mb2), .first_err_cycle(fe2));

  formal_random_checker #(.NUM_IN(2), .NUM_OUT(1), .SEED(64'h0), .WARMUP_CYCLES(1),
    .RUN_CYCLES(400), .LATENCY(0), .COUNT_MODE(0), .ERR_W(16)) u3 (
    .clk(clk), .reset(reset), .start(start), .stim(stim3), .dut_out(d3), .ref_out(r3),
    .ref_mask(m3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .mismatch_bits(mb3), .first_err_cycle(fe3));

  formal_random_checker #(.NUM_IN(16), .NUM_OUT(1), .SEED(SEED4), .WARMUP_CYCLES(1),
    .RUN_CYCLES(400), .LATENCY(0), .COUNT_MODE(0), .ERR_W(4)) u4 (
    .clk(clk), .reset(reset), .start(start), .stim(stim4), .dut_out(d4), .ref_out(r4),
    .ref_mask(1'b0), .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .mismatch_bits(mb4), .first_err_cycle(fe4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lfsr_model(input logic [63:0] seed, input int n);
    logic [63:0] q;
    q = (seed == 64'h0) ? 64'h1 : seed;
    for (int i = 0; i < n; i++) q = {q[62:0], q[63] ^ q[62] ^ q[60] ^ q[59]};
    return q;
  endfunction

  task automatic chk_u0_reset_state(input string tag);
    chk({tag, "_stim"}, stim0, 2'b00);
    chk({tag, "_busy"}, busy0, 1'b0);
    chk({tag, "_done"}, done0, 1'b0);
    chk({tag, "_pass"}, pass0, 1'b0);
    chk({tag, "_err"},  err0, 16'd0);
    chk({tag, "_mb"},   mb0, 1'b0);
    chk({tag, "_fe"},   fe0, 20'hFFFFF);
  endtask

  // One run from a start pulse. c is the RUN-cycle index of the cycle that
  // begins at the most recent rising edge (WARMUP is one cycle).
  task automatic do_run(input int lo, input int hi, input int one, input bit msk,
                        input int rst_at, input bit timing, input int stim_base,
                        input bit clr_chk);
    logic [63:0] m;
    bit hit;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (clr_chk) begin
      chk("u4_clr_err", err4, 4'd0);
      chk("u4_clr_mb",  mb4, 1'b0);
      chk("u4_clr_fe",  fe4, 20'hFFFFF);
    end
    for (int i = 1; i <= 600; i++) begin
      int c;
      @(posedge clk); #1;
      c = i - 1;
      hit     = ((c >= lo) && (c <= hi)) || (c == one);
      fault   = hit;
      mask_en = hit && msk;
      if (c == rst_at) begin
        chk("pre_rst_err", err0, 16'd5);
        reset = 1'b1;
        #1;
        chk_u0_reset_state("midrst");
        @(negedge clk) reset = 1'b0;
        fault = 1'b0; mask_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_done", done0, 1'b0);
        chk("post_rst_busy", busy0, 1'b0);
        return;
      end
      if (timing) begin
        if (c < 3) begin
          m = lfsr_model(64'h0, c);
          chk("u3_stim_seed0", stim3, m[1:0]);
        end
        if (c == 399) begin
          chk("u0_done_early", done0, 1'b0);
          chk("u0_busy_run",   busy0, 1'b1);
        end
        if (c == 400) chk("u0_done_ontime", done0, 1'b1);
        if (c == 402) chk("u2_done_drain", done2, 1'b0);
        if (c == 403) chk("u2_done_ontime", done2, 1'b1);
      end
      if (stim_base >= 0 && c < 3) begin
        m = lfsr_model(SEED4, stim_base + c);
        chk("u4_stim", stim4, m[15:0]);
      end
      if (done0 && done1 && done2 && done3 && done4) break;
    end
    fault = 1'b0; mask_en = 1'b0;
    chk("run_all_done", {done0, done1, done2, done3, done4}, 5'b11111);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; fault = 1'b0; mask_en = 1'b0;
    repeat (2) @(negedge clk);
    chk_u0_reset_state("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // A: matched outputs, latency pair, saturation, seed-zero fix
    do_run(-1, -1, -1, 1'b0, -1, 1'b1, -1, 1'b0);
    chk("A_u0_pass", pass0, 1'b1);
    chk("A_u0_err",  err0, 16'd0);
    chk("A_u0_mb",   mb0, 1'b0);
    chk("A_u0_fe",   fe0, 20'hFFFFF);
    chk("A_u1_pass", pass1, 1'b1);
    chk("A_u2_pass", pass2, 1'b1);
    chk("A_u2_err",  err2, 16'd0);
    chk("A_u3_err",  err3, 16'd2);
    chk("A_u3_pass", pass3, 1'b0);
    chk("A_u4_err_sat", err4, 4'd15);

    // B: fault on RUN cycles 10..14
    do_run(10, 14, -1, 1'b0, -1, 1'b0, -1, 1'b0);
    chk("B_u0_err",  err0, 16'd5);
    chk("B_u0_fe",   fe0, 20'd10);
    chk("B_u0_mb",   mb0, 1'b1);
    chk("B_u0_pass", pass0, 1'b0);
    chk("B_u1_err",  err1, 16'd1);
    chk("B_u1_fe",   fe1, 20'd10);

    // C: faults on 10..14 and 100
    do_run(10, 14, 100, 1'b0, -1, 1'b0, -1, 1'b0);
    chk("C_u0_err",  err0, 16'd6);
    chk("C_u1_err",  err1, 16'd2);
    chk("C_u1_pass", pass1, 1'b0);

    // D: same fault but the bit is masked on those cycles
    do_run(10, 14, -1, 1'b1, -1, 1'b0, -1, 1'b0);
    chk("D_u0_err",  err0, 16'd0);
    chk("D_u0_mb",   mb0, 1'b0);
    chk("D_u0_pass", pass0, 1'b1);

    // E: asynchronous reset at RUN cycle 50
    do_run(10, 14, -1, 1'b0, 50, 1'b0, -1, 1'b0);

    // F/G: saturation, counter clear on restart, LFSR continues across runs
    do_run(-1, -1, -1, 1'b0, -1, 1'b0, 0, 1'b0);
    chk("F_u4_err",  err4, 4'd15);
    chk("F_u4_fe",   fe4, 20'd0);
    chk("F_u4_mb",   mb4, 1'b1);
    chk("F_u4_pass", pass4, 1'b0);
    do_run(-1, -1, -1, 1'b0, -1, 1'b0, 401, 1'b1);
    chk("G_u4_err",  err4, 4'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
